alu_dispatch: RTL and testbench
===============================

ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 Parameter NREG, default 8, number of 16-bit general registers (fixed power of two; index width 3).
REQ-002 Port clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 Port req_valid  in  1  request present.
REQ-005 Port req_ready  out  1  dispatcher can accept; high only in IDLE.
REQ-006 Port req_op  in  8  opcode: 0x01-0x11 ALU ops, 0x80 LOADI, others NOP.
REQ-007 Port req_rd / req_ra / req_rb  in  3 each  destination, source A, source B register indices.
REQ-008 Port req_imm  in  16  immediate for LOADI.
REQ-009 Port alu_a / alu_b  out  16 each  operands to ALU (regfile[ra], regfile[rb]).
REQ-010 Port alu_op  out  8  opcode to ALU; 0x00 (ALU hold) outside ISSUE.
REQ-011 Port alu_cf  out  1  current architectural C flag.
REQ-012 Port alu_acc / alu_c  in  16 each  ALU low result / high result, registered inside ALU.
REQ-013 Port alu_c_flag / alu_z_flag / alu_o_flag  in  1 each  ALU flags.
REQ-014 Port flags  out  3  architectural {O,Z,C}.
REQ-015 Port done  out  1  one-cycle completion pulse.
REQ-016 Port div_err  out  1  one-cycle divide-by-zero pulse, coincident with done.
REQ-017 Port dbg_addr  in  3 / dbg_data  out  16  combinational register-file read.

Function
REQ-018 FSM states IDLE, ISSUE, WB; accept = req_valid & req_ready in IDLE latches op/rd/ra/rb/imm.
REQ-019 Accepted ALU op (0x01-0x11): IDLE->ISSUE; ISSUE drives alu_op=op, alu_a/alu_b from latched ra/rb; ISSUE->WB next edge; WB->IDLE next edge.
REQ-020 WB edge: ops 0x01-0x08, 0x0A-0x10 write alu_acc to rd; 0x09 (CMP), 0x11 (TEST) write nothing.
REQ-021 WB edge: ops 0x06 (MUL6), 0x08 (DIV6) additionally write alu_c to (rd+1) mod NREG.
REQ-022 WB flag update: 0x01-0x04, 0x09 load O,Z,C from ALU; 0x05-0x08, 0x11 load Z only; 0x0A-0x10 leave flags unchanged.
REQ-023 done registered high for exactly the cycle after WB edge (3 cycles after accept edge); req_ready high in that same cycle; max throughput one op per 3 cycles.
REQ-024 Divide-by-zero (0x07 with regfile[rb][7:0]==0, or 0x08 with regfile[rb]==0) detected in ISSUE: alu_op held 0x00, no write, flags unchanged, ISSUE->IDLE, done and div_err pulse next cycle.
REQ-025 LOADI (0x80): IDLE->WB directly, WB edge writes req_imm to rd, flags unchanged, done pulse next cycle.
REQ-026 NOP (any other opcode): IDLE->WB, no write, no flag change, done pulse; alu_op stays 0x00.
REQ-027 ra, rb, rd may alias; operands read in ISSUE reflect all prior completed writes.
REQ-028 If rd+1 wraps (rd=NREG-1) high word goes to register 0.
REQ-029 req_op/req_* ignored when req_ready low; no queuing.

Reset
REQ-030 rst_n low: state IDLE, all registers 0x0000, flags 3'b000, done 0, div_err 0, alu_op 0x00, alu_a/alu_b 0x0000, req_ready 1 after release.
REQ-031 Reset in ISSUE or WB aborts operation: no register or flag write, no done pulse.
REQ-032 ALU internal outputs are not reset; dispatcher correctness SHALL not depend on their value before the first ISSUE.

Verification
REQ-033 Reset then idle -> req_ready=1, flags=000, dbg_data=0x0000 for all 8 addresses.
REQ-034 LOADI r1=0x7FFF, LOADI r2=0x0001, ADD rd=3 ra=1 rb=2 -> r3=0x8000, flags O=1 Z=0 C=0, done exactly 3 cycles after ADD accept.
REQ-035 r1=0x1234, r2=0x0100, MUL6 rd=4 -> r4=0x3400, r5=0x0012, Z=0; repeat with rd=7 -> r7=0x3400, r0=0x0012.
REQ-036 r6=0x0000, DIV6 rd=3 ra=1 rb=6 -> done+div_err pulse, r3 and r4 unchanged, flags unchanged, alu_op never nonzero.
REQ-037 CMP ra=rb (equal values) -> flags Z=1 C=0 O=0, no register changes; then ADC 0xFFFF+0x0000 with C=1 -> result 0x0000, Z=1.
REQ-038 rst_n pulsed low during WB of LOADI r2=0xBEEF -> r2=0x0000, no done, req_ready=1 after release.

Source files
------------

// File: rtl/alu_dispatch.sv
// ALU dispatcher: latches one request, issues it to an external registered
// ALU, and writes results and flags back into a small register file.
module alu_dispatch #(
  parameter int NREG = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_op,
  input  logic [2:0]  req_rd,
  input  logic [2:0]  req_ra,
  input  logic [2:0]  req_rb,
  input  logic [15:0] req_imm,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [7:0]  alu_op,
  output logic        alu_cf,
  input  logic [15:0] alu_acc,
  input  logic [15:0] alu_c,
  input  logic        alu_c_flag,
  input  logic        alu_z_flag,
  input  logic        alu_o_flag,
  output logic [2:0]  flags,
  output logic        done,
  output logic        div_err,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WB
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  op_q;
  logic [2:0]  rd_q;
  logic [2:0]  ra_q;
  logic [2:0]  rb_q;
  logic [2:0]  rd_hi;
  logic [15:0] imm_q;
  logic [15:0] regs [NREG];
  logic [2:0]  flags_q;
  logic        accept;
  logic        req_alu;
  logic        div_zero;
  logic        wr_lo;
  logic        wr_hi;
  logic        fl_all;
  logic        fl_z;

  assign accept  = req_valid & req_ready;
  assign req_alu = (req_op >= 8'h01) && (req_op <= 8'h11);
  assign rd_hi   = rd_q + 3'd1;

  assign div_zero =
    ((op_q == 8'h07) && (regs[rb_q][7:0] == 8'h00)) ||
    ((op_q == 8'h08) && (regs[rb_q] == 16'h0000));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = req_alu ? ISSUE : WB;
      end
      ISSUE: begin
        state_nx = div_zero ? IDLE : WB;
      end
      WB: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    alu_op    = 8'h00;
    if ((state == ISSUE) && !div_zero) alu_op = op_q;
  end

  // Writeback decode by opcode class
  always_comb begin
    wr_lo  = 1'b0;
    wr_hi  = 1'b0;
    fl_all = 1'b0;
    fl_z   = 1'b0;
    unique case (1'b1)
      (op_q >= 8'h01) && (op_q <= 8'h04): begin
        wr_lo  = 1'b1;
        fl_all = 1'b1;
      end
      (op_q >= 8'h05) && (op_q <= 8'h08): begin
        wr_lo = 1'b1;
        wr_hi = (op_q == 8'h06) || (op_q == 8'h08);
        fl_z  = 1'b1;
      end
      (op_q == 8'h09): begin
        fl_all = 1'b1;
      end
      (op_q >= 8'h0A) && (op_q <= 8'h10): begin
        wr_lo = 1'b1;
      end
      (op_q == 8'h11): begin
        fl_z = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= 8'h00;
      rd_q    <= 3'd0;
      ra_q    <= 3'd0;
      rb_q    <= 3'd0;
      imm_q   <= 16'h0000;
      flags_q <= 3'b000;
      done    <= 1'b0;
      div_err <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= 16'h0000;
    end else begin
      done    <= 1'b0;
      div_err <= 1'b0;
      if (accept) begin
        op_q  <= req_op;
        rd_q  <= req_rd;
        ra_q  <= req_ra;
        rb_q  <= req_rb;
        imm_q <= req_imm;
      end
      if ((state == ISSUE) && div_zero) begin
        done    <= 1'b1;
        div_err <= 1'b1;
      end
      if (state == WB) begin
        done <= 1'b1;
        if (op_q == 8'h80) regs[rd_q] <= imm_q;
        else if (wr_lo)    regs[rd_q] <= alu_acc;
        if (wr_hi)  regs[rd_hi] <= alu_c;
        if (fl_all) flags_q <= {alu_o_flag, alu_z_flag, alu_c_flag};
        if (fl_z)   flags_q[1] <= alu_z_flag;
      end
    end
  end

  assign alu_a    = regs[ra_q];
  assign alu_b    = regs[rb_q];
  assign alu_cf   = flags_q[0];
  assign flags    = flags_q;
  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a small registered ALU model
// answering ADD, ADC, MUL6, DIV6 and CMP.
module tb_alu_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_op;
  logic [2:0]  req_rd;
  logic [2:0]  req_ra;
  logic [2:0]  req_rb;
  logic [15:0] req_imm;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [7:0]  alu_op;
  logic        alu_cf;
  logic [15:0] alu_acc = 16'h0;
  logic [15:0] alu_c = 16'h0;
  logic        alu_c_flag = 1'b0;
  logic        alu_z_flag = 1'b0;
  logic        alu_o_flag = 1'b0;
  logic [2:0]  flags;
  logic        done;
  logic        div_err;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_dispatch dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rd(req_rd),
    .req_ra(req_ra), .req_rb(req_rb),
    .req_imm(req_imm),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_cf(alu_cf),
    .alu_acc(alu_acc), .alu_c(alu_c),
    .alu_c_flag(alu_c_flag),
    .alu_z_flag(alu_z_flag),
    .alu_o_flag(alu_o_flag),
    .flags(flags), .done(done),
    .div_err(div_err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  logic [16:0] s_nx;
  logic [31:0] p_nx;
  logic [15:0] acc_nx;
  logic [15:0] c_nx;
  logic        cf_nx;
  logic        zf_nx;
  logic        of_nx;

  always_comb begin
    s_nx   = 17'h0;
    p_nx   = 32'h0;
    acc_nx = alu_acc;
    c_nx   = alu_c;
    cf_nx  = alu_c_flag;
    zf_nx  = alu_z_flag;
    of_nx  = alu_o_flag;
    case (alu_op)
      8'h01, 8'h02: begin
        s_nx = {1'b0, alu_a} + {1'b0, alu_b}
             + {16'h0, (alu_op == 8'h02) & alu_cf};
        acc_nx = s_nx[15:0];
        cf_nx  = s_nx[16];
        zf_nx  = (s_nx[15:0] == 16'h0);
        of_nx  = (alu_a[15] == alu_b[15]) &&
                 (s_nx[15] != alu_a[15]);
      end
      8'h06: begin
        p_nx   = alu_a * alu_b;
        acc_nx = p_nx[15:0];
        c_nx   = p_nx[31:16];
        zf_nx  = (p_nx == 32'h0);
      end
      8'h08: begin
        acc_nx = alu_a / alu_b;
        c_nx   = alu_a % alu_b;
        zf_nx  = (acc_nx == 16'h0);
      end
      8'h09: begin
        s_nx  = {1'b0, alu_a} - {1'b0, alu_b};
        cf_nx = s_nx[16];
        zf_nx = (s_nx[15:0] == 16'h0);
        of_nx = (alu_a[15] != alu_b[15]) &&
                (s_nx[15] != alu_a[15]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (alu_op != 8'h00) begin
      alu_acc    <= acc_nx;
      alu_c      <= c_nx;
      alu_c_flag <= cf_nx;
      alu_z_flag <= zf_nx;
      alu_o_flag <= of_nx;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic rdreg(input logic [2:0] idx,
                       output logic [15:0] val);
    dbg_addr = idx;
    #1;
    val = dbg_data;
  endtask

  task automatic send(input logic [7:0] op,
                      input logic [2:0] rd,
                      input logic [2:0] ra,
                      input logic [2:0] rb,
                      input logic [15:0] imm,
                      output int lat,
                      output logic derr,
                      output logic saw_op);
    lat    = 0;
    derr   = 1'b0;
    saw_op = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_rd    = rd;
    req_ra    = ra;
    req_rb    = rb;
    req_imm   = imm;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (alu_op != 8'h00) saw_op = 1'b1;
      if (done) begin
        lat  = n;
        derr = div_err;
        break;
      end
    end
    if (lat == 0) check("done_timeout", 0, 1);
  endtask

  int          lat;
  logic        derr;
  logic        sop;
  logic [15:0] v;
  logic        saw_done;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 8'h00;
    req_rd    = 3'd0;
    req_ra    = 3'd0;
    req_rb    = 3'd0;
    req_imm   = 16'h0;
    dbg_addr  = 3'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_ready", req_ready, 1);
    check("rst_flags", flags, 3'b000);
    check("rst_done", done, 0);
    check("rst_aluop", alu_op, 8'h00);
    for (int i = 0; i < 8; i++) begin
      rdreg(i[2:0], v);
      check($sformatf("rst_r%0d", i), v, 16'h0);
    end

    send(8'h80, 3'd1, 3'd0, 3'd0, 16'h7FFF, lat, derr, sop);
    check("loadi_lat", lat, 2);
    send(8'h80, 3'd2, 3'd0, 3'd0, 16'h0001, lat, derr, sop);
    send(8'h01, 3'd3, 3'd1, 3'd2, 16'h0, lat, derr, sop);
    check("add_lat", lat, 3);
    check("add_ready", req_ready, 1);
    rdreg(3'd3, v);
    check("add_r3", v, 16'h8000);
    check("add_flags", flags, 3'b100);

    send(8'h80, 3'd1, 3'd0, 3'd0, 16'h1234, lat, derr, sop);
    send(8'h80, 3'd2, 3'd0, 3'd0, 16'h0100, lat, derr, sop);
    send(8'h06, 3'd4, 3'd1, 3'd2, 16'h0, lat, derr, sop);
    rdreg(3'd4, v);
    check("mul_r4", v, 16'h3400);
    rdreg(3'd5, v);
    check("mul_r5", v, 16'h0012);
    check("mul_flags", flags, 3'b100);
    send(8'h06, 3'd7, 3'd1, 3'd2, 16'h0, lat, derr, sop);
    rdreg(3'd7, v);
    check("mulw_r7", v, 16'h3400);
    rdreg(3'd0, v);
    check("mulw_r0", v, 16'h0012);

    send(8'h80, 3'd6, 3'd0, 3'd0, 16'h0000, lat, derr, sop);
    send(8'h08, 3'd3, 3'd1, 3'd6, 16'h0, lat, derr, sop);
    check("div0_lat", lat, 2);
    check("div0_err", derr, 1);
    check("div0_aluop", sop, 0);
    rdreg(3'd3, v);
    check("div0_r3", v, 16'h8000);
    rdreg(3'd4, v);
    check("div0_r4", v, 16'h3400);
    check("div0_flags", flags, 3'b100);

    send(8'h09, 3'd5, 3'd1, 3'd1, 16'h0, lat, derr, sop);
    check("cmp_err", derr, 0);
    check("cmp_flags", flags, 3'b010);
    rdreg(3'd5, v);
    check("cmp_r5", v, 16'h0012);
    rdreg(3'd1, v);
    check("cmp_r1", v, 16'h1234);

    send(8'h80, 3'd2, 3'd0, 3'd0, 16'hFFFF, lat, derr, sop);
    send(8'h01, 3'd3, 3'd2, 3'd2, 16'h0, lat, derr, sop);
    check("carry_flags", flags, 3'b001);
    check("carry_cf", alu_cf, 1);
    send(8'h02, 3'd4, 3'd2, 3'd6, 16'h0, lat, derr, sop);
    rdreg(3'd4, v);
    check("adc_r4", v, 16'h0000);
    check("adc_flags", flags, 3'b011);

    send(8'h42, 3'd1, 3'd0, 3'd0, 16'h0, lat, derr, sop);
    check("nop_lat", lat, 2);
    check("nop_aluop", sop, 0);
    rdreg(3'd1, v);
    check("nop_r1", v, 16'h1234);

    saw_done = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 8'h80;
    req_rd    = 3'd2;
    req_imm   = 16'hBEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_done", saw_done, 0);
    check("abort_ready", req_ready, 1);
    rdreg(3'd2, v);
    check("abort_r2", v, 16'h0000);
    check("abort_flags", flags, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
